index_ld_sequencer: RTL and testbench

Multi-cycle sequencer for the indexed-load/store group of the prefixed opcode space: LD r,(IX+d), LD r,(IY+d), LD (IX+d),r and LD (IY+d),r. It sits between the opcode fetch stream and the memory/register-file ports. It consumes the DD/FD prefix, opcode and displacement bytes, computes the effective address, runs the memory transaction and writes back. It generalises the single-cycle indexed-LD decode step to a configurable address width and to prefix chains of configurable length, and adds an unhandled-opcode hand-off.

---
 rtl/index_ld_sequencer_if.sv | 29 ++
 rtl/index_ld_sequencer.sv | 177 +++++++++++++++++
 tb/tb_index_ld_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/index_ld_sequencer_if.sv
// Fetch-byte stream and memory request bus shared by the indexed-load/store sequencer
// and its environment. "master" is the sequencer side.
interface index_ld_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic [7:0]        mem_rdata;

  modport master (
    input  byte_valid, byte_in,
    output byte_ready,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output byte_valid, byte_in,
    input  byte_ready,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/index_ld_sequencer.sv
// Multi-cycle sequencer for LD r,(IX/IY+d) and LD (IX/IY+d),r with prefix chains.
// Define NORZ_XIX_LDN_EN to add LD (IX/IY+d),n through an extra IMM state.
module index_ld_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int PREFIX_MAX = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  index_ld_sequencer_if.master bus,
  input  logic [ADDR_W-1:0]    ix,
  input  logic [ADDR_W-1:0]    iy,
  output logic [2:0]           rd_sel,
  input  logic [7:0]           rd_data,
  output logic                 wr_en,
  output logic [2:0]           wr_sel,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 unhandled,
  output logic [7:0]           unhandled_op,
  output logic                 unhandled_is_y,
  output logic                 prefix_overflow
);

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    DISP,
`ifdef NORZ_XIX_LDN_EN
    IMM,
`endif
    MEM,
    WB
  } state_t;

  state_t            state;
  logic              is_y;
  logic [3:0]        prefix_cnt;
  logic              is_store;
  logic              is_imm;
  logic [2:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata_q;
  logic              unh_q;
  logic [7:0]        unh_op_q;
  logic              unh_y_q;
  logic              ovf_q;

  logic              accept;
  logic              is_prefix;
  logic              is_load_op;
  logic              is_store_op;
  logic [ADDR_W-1:0] disp_ext;

  assign accept      = bus.byte_valid && bus.byte_ready;
  assign is_prefix   = (bus.byte_in == 8'hDD) || (bus.byte_in == 8'hFD);
  // 0x76 (HALT slot) matches both bit patterns and must fall through to unhandled
  assign is_load_op  = (bus.byte_in[7:6] == 2'b01) && (bus.byte_in[2:0] == 3'b110) &&
                       (bus.byte_in[5:3] != 3'b110);
  assign is_store_op = (bus.byte_in[7:3] == 5'b01110) && (bus.byte_in[2:0] != 3'b110);
  assign disp_ext    = ADDR_W'(signed'(bus.byte_in));

`ifdef NORZ_XIX_LDN_EN
  assign bus.byte_ready = (state == IDLE) || (state == OPC) || (state == DISP) || (state == IMM);
`else
  assign bus.byte_ready = (state == IDLE) || (state == OPC) || (state == DISP);
`endif

  assign bus.mem_valid   = (state == MEM);
  assign bus.mem_we      = bus.mem_valid && is_store;
  assign bus.mem_addr    = bus.mem_valid ? addr : '0;
  assign bus.mem_wdata   = bus.mem_we ? wdata : 8'h00;
  assign rd_sel          = (state == DISP) ? reg_sel : 3'd0;
  assign wr_en           = (state == WB);
  assign wr_sel          = wr_en ? reg_sel : 3'd0;
  assign wr_data         = wr_en ? rdata_q : 8'h00;
  assign busy            = (state != IDLE);
  assign done            = wr_en || (bus.mem_we && bus.mem_ready);
  assign unhandled       = unh_q;
  assign unhandled_op    = unh_q ? unh_op_q : 8'h00;
  assign unhandled_is_y  = unh_q && unh_y_q;
  assign prefix_overflow = ovf_q;

  // Main sequencer; unhandled/overflow pulses are registered and land in the IDLE cycle after
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      is_y       <= 1'b0;
      prefix_cnt <= 4'd0;
      is_store   <= 1'b0;
      is_imm     <= 1'b0;
      reg_sel    <= 3'd0;
      addr       <= '0;
      wdata      <= 8'h00;
      rdata_q    <= 8'h00;
      unh_q      <= 1'b0;
      unh_op_q   <= 8'h00;
      unh_y_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unh_q <= 1'b0;
      ovf_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_prefix) begin
            is_y       <= (bus.byte_in == 8'hFD);
            prefix_cnt <= 4'd1;
            state      <= OPC;
          end
        end
        OPC: begin
          if (accept) begin
            is_imm <= 1'b0;
            if (is_prefix) begin
              if (prefix_cnt == 4'(PREFIX_MAX)) begin
                ovf_q <= 1'b1;
                state <= IDLE;
              end else begin
                prefix_cnt <= prefix_cnt + 4'd1;
                is_y       <= (bus.byte_in == 8'hFD);
              end
            end else if (is_load_op) begin
              is_store <= 1'b0;
              reg_sel  <= bus.byte_in[5:3];
              state    <= DISP;
            end else if (is_store_op) begin
              is_store <= 1'b1;
              reg_sel  <= bus.byte_in[2:0];
              state    <= DISP;
`ifdef NORZ_XIX_LDN_EN
            end else if (bus.byte_in == 8'h36) begin
              is_store <= 1'b1;
              is_imm   <= 1'b1;
              reg_sel  <= 3'd0;
              state    <= DISP;
`endif
            end else begin
              unh_q    <= 1'b1;
              unh_op_q <= bus.byte_in;
              unh_y_q  <= is_y;
              state    <= IDLE;
            end
          end
        end
        DISP: begin
          if (accept) begin
            addr  <= (is_y ? iy : ix) + disp_ext;
            wdata <= rd_data;
`ifdef NORZ_XIX_LDN_EN
            state <= is_imm ? IMM : MEM;
`else
            state <= MEM;
`endif
          end
        end
`ifdef NORZ_XIX_LDN_EN
        IMM: begin
          if (accept) begin
            wdata <= bus.byte_in;
            state <= MEM;
          end
        end
`endif
        MEM: begin
          if (bus.mem_ready) begin
            rdata_q <= bus.mem_rdata;
            state   <= is_store ? IDLE : WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_index_ld_sequencer.sv
// Self-checking bench for index_ld_sequencer: directed scenarios plus randomized
// instruction streams compared against a byte-level reference decoder.
module tb_index_ld_sequencer;
  localparam int ADDR_W     = 16;
  localparam int PREFIX_MAX = 4;
  localparam int K_NONE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_UNH   = 3;
  localparam int K_OVF   = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ADDR_W-1:0] ix, iy;
  logic [2:0]        rd_sel;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [7:0]        wr_data;
  logic              busy, done, unhandled;
  logic [7:0]        unhandled_op;
  logic              unhandled_is_y, prefix_overflow;
  logic [7:0]        regs [8];

  int tests_run = 0;
  int tests_failed = 0;

  index_ld_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  index_ld_sequencer #(.ADDR_W(ADDR_W), .PREFIX_MAX(PREFIX_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.master), .ix(ix), .iy(iy),
    .rd_sel(rd_sel), .rd_data(rd_data), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy(busy), .done(done), .unhandled(unhandled), .unhandled_op(unhandled_op),
    .unhandled_is_y(unhandled_is_y), .prefix_overflow(prefix_overflow)
  );

  always #5 CLK = ~CLK;
  assign rd_data = regs[rd_sel];

  logic [7:0]        seq [16];
  int                seq_n, byte_stall_pct, mem_stall;
  logic [7:0]        rdata_val;
  int                obs_mem, obs_done, obs_done_cyc, obs_wr, obs_unh, obs_ovf;
  int                obs_excl, obs_rdybad, obs_unstable, obs_timeout;
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_we, obs_unh_y;
  logic [7:0]        obs_wdata, obs_wr_data, obs_unh_op;
  logic [2:0]        obs_wr_sel;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [2:0]        wsel;
    logic [7:0]        op;
    logic              y;
  } exp_t;

  // Reference decoder: reads the byte stream the way the instruction set defines it
  function automatic exp_t model_run();
    exp_t e;
    int np = 0;
    int i = 0;
    int d;
    logic [7:0] op;
    logic [ADDR_W-1:0] base;
    e.kind = K_NONE; e.addr = '0; e.wdata = 8'h00; e.wsel = 3'd0; e.op = 8'h00; e.y = 1'b0;
    while (i < seq_n && (seq[i] == 8'hDD || seq[i] == 8'hFD)) begin
      np++;
      e.y = (seq[i] == 8'hFD);
      if (np > PREFIX_MAX) begin
        e.kind = K_OVF;
        return e;
      end
      i++;
    end
    if (np == 0 || i >= seq_n) return e;
    op = seq[i];
    e.op = op;
    if (op != 8'h76 && op[7:6] == 2'b01 && op[2:0] == 3'd6) begin
      e.kind = K_LOAD; e.wsel = op[5:3]; e.wdata = rdata_val;
    end else if (op != 8'h76 && op[7:3] == 5'b01110) begin
      e.kind = K_STORE; e.wdata = regs[op[2:0]];
`ifdef NORZ_XIX_LDN_EN
    end else if (op == 8'h36) begin
      e.kind = K_STORE; e.wdata = seq[i+2];
`endif
    end else begin
      e.kind = K_UNH;
    end
    if (e.kind == K_LOAD || e.kind == K_STORE) begin
      d = int'(seq[i+1]);
      if (d > 127) d -= 256;
      base = e.y ? iy : ix;
      e.addr = ADDR_W'(int'(base) + d);
    end
    return e;
  endfunction

  // Feeds seq[] with optional fetch stalls, plays memory, and records what the DUT did
  task automatic run_seq();
    int idx = 0;
    int idle = 0;
    int waited = 0;
    bit holding = 1'b0;
    logic [ADDR_W-1:0] a0;
    logic w0;
    logic [7:0] d0;
    a0 = '0; w0 = 1'b0; d0 = 8'h00;
    obs_mem = 0; obs_done = 0; obs_done_cyc = 0; obs_wr = 0; obs_unh = 0; obs_ovf = 0;
    obs_excl = 0; obs_rdybad = 0; obs_unstable = 0; obs_timeout = 1;
    obs_addr = '0; obs_we = 1'b0; obs_wdata = 8'h00; obs_wr_data = 8'h00; obs_wr_sel = 3'd0;
    obs_unh_op = 8'h00; obs_unh_y = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge CLK);
      if (idx < seq_n && int'($urandom_range(99)) >= byte_stall_pct) begin
        bus.byte_valid = 1'b1;
        bus.byte_in = seq[idx];
      end else begin
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'($urandom);
      end
      bus.mem_ready = (waited >= mem_stall);
      bus.mem_rdata = bus.mem_ready ? rdata_val : 8'($urandom);
      #1;
      if (bus.mem_valid) begin
        if (!holding) begin
          a0 = bus.mem_addr; w0 = bus.mem_we; d0 = bus.mem_wdata; holding = 1'b1;
        end else if (bus.mem_addr !== a0 || bus.mem_we !== w0 || bus.mem_wdata !== d0) begin
          obs_unstable++;
        end
        if (bus.mem_ready) begin
          obs_mem++; obs_addr = a0; obs_we = w0; obs_wdata = d0; holding = 1'b0; waited = 0;
        end else begin
          waited++;
        end
      end
      if (done) begin obs_done++; obs_done_cyc = cyc; end
      if (wr_en) begin obs_wr++; obs_wr_sel = wr_sel; obs_wr_data = wr_data; end
      if (unhandled) begin obs_unh++; obs_unh_op = unhandled_op; obs_unh_y = unhandled_is_y; end
      if (prefix_overflow) obs_ovf++;
      if (int'(done) + int'(unhandled) + int'(prefix_overflow) > 1) obs_excl++;
      if (bus.byte_ready && (bus.mem_valid || wr_en)) obs_rdybad++;
      if (bus.byte_valid && bus.byte_ready) idx++;
      if (idx == seq_n && !busy) idle++; else idle = 0;
      if (idle >= 3) begin obs_timeout = 0; break; end
    end
    bus.byte_valid = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    tests_run++; if (bus.byte_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_byte_ready: got %b expected 1", bus.byte_ready); end
    tests_run++; if ({busy, done, wr_en, unhandled, unhandled_is_y, prefix_overflow, bus.mem_valid, bus.mem_we} !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 00000000", {busy, done, wr_en, unhandled, unhandled_is_y, prefix_overflow, bus.mem_valid, bus.mem_we}); end
    tests_run++; if ({bus.mem_addr, bus.mem_wdata, wr_data, unhandled_op, rd_sel, wr_sel} !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, wr_data, unhandled_op, rd_sel, wr_sel}); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_load();
    ix = 16'h1000; iy = 16'h7777; rdata_val = 8'h5A; byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hDD; seq[1] = 8'h46; seq[2] = 8'h05; seq_n = 3;
    run_seq();
    tests_run++; if (obs_mem !== 1 || obs_we !== 1'b0 || obs_addr !== 16'h1005) begin
      tests_failed++; $display("[TB] FAIL load_mem: got cnt=%0d we=%b addr=%h expected 1 0 1005", obs_mem, obs_we, obs_addr); end
    tests_run++; if (obs_wr !== 1 || obs_wr_sel !== 3'd0 || obs_wr_data !== 8'h5A) begin
      tests_failed++; $display("[TB] FAIL load_wb: got cnt=%0d sel=%0d data=%h expected 1 0 5a", obs_wr, obs_wr_sel, obs_wr_data); end
    tests_run++; if (obs_done !== 1 || obs_done_cyc !== 5) begin
      tests_failed++; $display("[TB] FAIL load_latency: got done=%0d cyc=%0d expected 1 5", obs_done, obs_done_cyc); end
  endtask

  task automatic test_store();
    ix = 16'h1234; iy = 16'h2000; regs[7] = 8'h33; byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hFD; seq[1] = 8'h77; seq[2] = 8'hFE; seq_n = 3;
    run_seq();
    tests_run++; if (obs_mem !== 1 || obs_we !== 1'b1 || obs_addr !== 16'h1FFE || obs_wdata !== 8'h33) begin
      tests_failed++; $display("[TB] FAIL store_mem: got cnt=%0d we=%b addr=%h data=%h expected 1 1 1ffe 33", obs_mem, obs_we, obs_addr, obs_wdata); end
    tests_run++; if (obs_done !== 1 || obs_done_cyc !== 4 || obs_wr !== 0) begin
      tests_failed++; $display("[TB] FAIL store_done: got done=%0d cyc=%0d wr=%0d expected 1 4 0", obs_done, obs_done_cyc, obs_wr); end
  endtask

  task automatic test_prefix_chain();
    ix = 16'hFFFF; iy = 16'h0100; rdata_val = 8'hC3; byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hDD; seq[1] = 8'hFD; seq[2] = 8'hDD; seq[3] = 8'h7E; seq[4] = 8'h02; seq_n = 5;
    run_seq();
    tests_run++; if (obs_mem !== 1 || obs_addr !== 16'h0001) begin
      tests_failed++; $display("[TB] FAIL chain_addr: got cnt=%0d addr=%h expected 1 0001", obs_mem, obs_addr); end
    tests_run++; if (obs_wr !== 1 || obs_wr_sel !== 3'd7 || obs_wr_data !== 8'hC3) begin
      tests_failed++; $display("[TB] FAIL chain_wb: got cnt=%0d sel=%0d data=%h expected 1 7 c3", obs_wr, obs_wr_sel, obs_wr_data); end
    for (int k = 0; k < 5; k++) seq[k] = 8'hDD;
    seq_n = 5;
    run_seq();
    tests_run++; if (obs_ovf !== 1 || obs_mem !== 0 || obs_done !== 0 || obs_unh !== 0) begin
      tests_failed++; $display("[TB] FAIL overflow: got ovf=%0d mem=%0d done=%0d unh=%0d expected 1 0 0 0", obs_ovf, obs_mem, obs_done, obs_unh); end
  endtask

  task automatic test_unhandled();
    byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hDD; seq[1] = 8'h76; seq_n = 2;
    run_seq();
    tests_run++; if (obs_unh !== 1 || obs_unh_op !== 8'h76 || obs_unh_y !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unh_76: got cnt=%0d op=%h y=%b expected 1 76 0", obs_unh, obs_unh_op, obs_unh_y); end
    tests_run++; if (obs_mem !== 0 || obs_done !== 0) begin
      tests_failed++; $display("[TB] FAIL unh_no_mem: got mem=%0d done=%0d expected 0 0", obs_mem, obs_done); end
    seq[0] = 8'hDD; seq[1] = 8'hFD; seq[2] = 8'hC9; seq_n = 3;
    run_seq();
    tests_run++; if (obs_unh !== 1 || obs_unh_op !== 8'hC9 || obs_unh_y !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL unh_fd: got cnt=%0d op=%h y=%b expected 1 c9 1", obs_unh, obs_unh_op, obs_unh_y); end
  endtask

  task automatic test_mem_stall();
    ix = 16'h1000; rdata_val = 8'h99; byte_stall_pct = 0; mem_stall = 3;
    seq[0] = 8'hDD; seq[1] = 8'h5E; seq[2] = 8'h05; seq_n = 3;
    run_seq();
    tests_run++; if (obs_unstable !== 0 || obs_addr !== 16'h1005 || obs_rdybad !== 0) begin
      tests_failed++; $display("[TB] FAIL stall_stable: got unstable=%0d addr=%h rdybad=%0d expected 0 1005 0", obs_unstable, obs_addr, obs_rdybad); end
    tests_run++; if (obs_done_cyc !== 8 || obs_wr_sel !== 3'd3 || obs_wr_data !== 8'h99) begin
      tests_failed++; $display("[TB] FAIL stall_wb: got cyc=%0d sel=%0d data=%h expected 8 3 99", obs_done_cyc, obs_wr_sel, obs_wr_data); end
    mem_stall = 0;
  endtask

  task automatic test_reset_in_mem();
    int idx = 0;
    int found = 0;
    int dones = 0;
    int valids = 0;
    ix = 16'h4000;
    seq[0] = 8'hDD; seq[1] = 8'h4E; seq[2] = 8'h01;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge CLK);
      bus.byte_valid = (idx < 3);
      bus.byte_in = (idx < 3) ? seq[idx] : 8'h00;
      bus.mem_ready = 1'b0;
      #1;
      if (bus.mem_valid) found = 1;
      if (bus.byte_valid && bus.byte_ready) idx++;
    end
    bus.byte_valid = 1'b0;
    tests_run++; if (found !== 1) begin tests_failed++; $display("[TB] FAIL rst_mem_reach: got %0d expected 1", found); end
    #2;
    RESET = 1'b1;
    #1;
    tests_run++; if ({bus.mem_valid, bus.mem_we, busy, done, bus.byte_ready} !== 5'b00001 || bus.mem_addr !== '0) begin
      tests_failed++; $display("[TB] FAIL rst_mem_async: got %b addr=%h expected 00001 0000", {bus.mem_valid, bus.mem_we, busy, done, bus.byte_ready}, bus.mem_addr); end
    @(negedge CLK);
    RESET = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      #1;
      if (done || wr_en) dones++;
      if (bus.mem_valid) valids++;
    end
    bus.mem_ready = 1'b0;
    tests_run++; if (dones !== 0 || valids !== 0) begin
      tests_failed++; $display("[TB] FAIL rst_mem_quiet: got done=%0d valid=%0d expected 0 0", dones, valids); end
  endtask

  task automatic test_store_imm();
    ix = 16'h0010; byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hDD; seq[1] = 8'h36; seq[2] = 8'h10; seq[3] = 8'hAB;
`ifdef NORZ_XIX_LDN_EN
    seq_n = 4;
    run_seq();
    tests_run++; if (obs_mem !== 1 || obs_we !== 1'b1 || obs_addr !== 16'h0020 || obs_wdata !== 8'hAB || obs_done_cyc !== 5) begin
      tests_failed++; $display("[TB] FAIL imm_store: got cnt=%0d we=%b addr=%h data=%h cyc=%0d expected 1 1 0020 ab 5", obs_mem, obs_we, obs_addr, obs_wdata, obs_done_cyc); end
`else
    seq_n = 2;
    run_seq();
    tests_run++; if (obs_unh !== 1 || obs_unh_op !== 8'h36 || obs_mem !== 0) begin
      tests_failed++; $display("[TB] FAIL imm_unh: got cnt=%0d op=%h mem=%0d expected 1 36 0", obs_unh, obs_unh_op, obs_mem); end
`endif
  endtask

  task automatic test_back_to_back();
    ix = 16'h1000; iy = 16'h2000; rdata_val = 8'h5A; byte_stall_pct = 0; mem_stall = 0;
    seq[0] = 8'hDD; seq[1] = 8'h46; seq[2] = 8'h05;
    seq[3] = 8'hFD; seq[4] = 8'h7E; seq[5] = 8'h03; seq_n = 6;
    run_seq();
    tests_run++; if (obs_done !== 2 || obs_done_cyc !== 10 || obs_wr !== 2) begin
      tests_failed++; $display("[TB] FAIL b2b_timing: got done=%0d cyc=%0d wr=%0d expected 2 10 2", obs_done, obs_done_cyc, obs_wr); end
    tests_run++; if (obs_addr !== 16'h2003 || obs_wr_sel !== 3'd7) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got addr=%h sel=%0d expected 2003 7", obs_addr, obs_wr_sel); end
  endtask

  task automatic test_random();
    exp_t e;
    int np, r, sel;
    logic [7:0] op;
    for (int t = 0; t < 40; t++) begin
      ix = 16'($urandom); iy = 16'($urandom); rdata_val = 8'($urandom);
      for (int k = 0; k < 8; k++) regs[k] = 8'($urandom);
      byte_stall_pct = int'($urandom_range(40));
      mem_stall = int'($urandom_range(3));
      np = ($urandom_range(7) == 0) ? PREFIX_MAX + 1 : int'($urandom_range(PREFIX_MAX, 1));
      seq_n = 0;
      for (int k = 0; k < np; k++) begin
        seq[seq_n] = ($urandom_range(1) == 1) ? 8'hFD : 8'hDD;
        seq_n++;
      end
      if (np <= PREFIX_MAX) begin
        r = int'($urandom_range(9));
        sel = int'($urandom_range(7));
        if (sel == 6) sel = 7;
        if (r < 4) op = {2'b01, 3'(sel), 3'b110};
        else if (r < 8) op = {5'b01110, 3'(sel)};
        else if (r == 8) op = 8'h36;
        else begin
          do op = 8'($urandom); while (op[7:6] == 2'b01 || op == 8'h36 || op == 8'hDD || op == 8'hFD);
          if ($urandom_range(1) == 1) op = 8'h76;
        end
        seq[seq_n] = op; seq_n++;
        if (r < 8) begin seq[seq_n] = 8'($urandom); seq_n++; end
`ifdef NORZ_XIX_LDN_EN
        if (r == 8) begin seq[seq_n] = 8'($urandom); seq[seq_n+1] = 8'($urandom); seq_n += 2; end
`endif
      end
      e = model_run();
      run_seq();
      tests_run++; if (obs_timeout !== 0) begin tests_failed++; $display("[TB] FAIL rnd%0d_timeout: got 1 expected 0", t); end
      tests_run++; if (obs_done !== ((e.kind == K_LOAD || e.kind == K_STORE) ? 1 : 0) || obs_mem !== obs_done) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_done: got done=%0d mem=%0d expected kind %0d", t, obs_done, obs_mem, e.kind); end
      if (e.kind == K_LOAD || e.kind == K_STORE) begin
        tests_run++; if (obs_addr !== e.addr || obs_we !== (e.kind == K_STORE)) begin
          tests_failed++; $display("[TB] FAIL rnd%0d_addr: got %h we=%b expected %h we=%b", t, obs_addr, obs_we, e.addr, e.kind == K_STORE); end
      end
      if (e.kind == K_STORE) begin
        tests_run++; if (obs_wdata !== e.wdata) begin tests_failed++; $display("[TB] FAIL rnd%0d_wdata: got %h expected %h", t, obs_wdata, e.wdata); end
      end
      tests_run++; if (obs_wr !== ((e.kind == K_LOAD) ? 1 : 0)) begin tests_failed++; $display("[TB] FAIL rnd%0d_wr: got %0d expected kind %0d", t, obs_wr, e.kind); end
      if (e.kind == K_LOAD) begin
        tests_run++; if (obs_wr_sel !== e.wsel || obs_wr_data !== e.wdata) begin
          tests_failed++; $display("[TB] FAIL rnd%0d_wb: got %0d/%h expected %0d/%h", t, obs_wr_sel, obs_wr_data, e.wsel, e.wdata); end
      end
      tests_run++; if (obs_unh !== ((e.kind == K_UNH) ? 1 : 0) || obs_ovf !== ((e.kind == K_OVF) ? 1 : 0)) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_pulses: got unh=%0d ovf=%0d expected kind %0d", t, obs_unh, obs_ovf, e.kind); end
      if (e.kind == K_UNH) begin
        tests_run++; if (obs_unh_op !== e.op || obs_unh_y !== e.y) begin
          tests_failed++; $display("[TB] FAIL rnd%0d_unh: got %h/%b expected %h/%b", t, obs_unh_op, obs_unh_y, e.op, e.y); end
      end
      tests_run++; if (obs_excl !== 0 || obs_rdybad !== 0 || obs_unstable !== 0) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_rules: got excl=%0d rdybad=%0d unstable=%0d expected 0 0 0", t, obs_excl, obs_rdybad, obs_unstable); end
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00; bus.mem_ready = 1'b0; bus.mem_rdata = 8'h00;
    ix = '0; iy = '0; rdata_val = 8'h00; seq_n = 0; byte_stall_pct = 0; mem_stall = 0;
    for (int k = 0; k < 8; k++) regs[k] = 8'(k * 17);
    for (int k = 0; k < 16; k++) seq[k] = 8'h00;
    test_reset();
    test_load();
    test_store();
    test_prefix_chain();
    test_unhandled();
    test_mem_stall();
    test_reset_in_mem();
    test_store_imm();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
